// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types and constants for the ID-stage branch resolution controller.
// Holds the resolver FSM states, 2-bit counter encodings and the saturating counter update.
package bp_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_OPND = 2'd1,
    FLUSH     = 2'd2
  } state_e;

  localparam logic [1:0] SNT       = 2'b00;
  localparam logic [1:0] WNT       = 2'b01;
  localparam logic [1:0] WT        = 2'b10;
  localparam logic [1:0] ST        = 2'b11;
  localparam logic [1:0] BHT_RESET = ST;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      if (ctr == ST) begin
        nxt = ST;
      end else begin
        nxt = ctr + 2'b01;
      end
    end else begin
      if (ctr == SNT) begin
        nxt = SNT;
      end else begin
        nxt = ctr - 2'b01;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Pipeline-facing signal bundle of the branch resolution controller.
// Optional macro BP_PERF_CNT_EN adds the branch / mispredict performance counters.
interface branch_resolve_ctrl_if #(
  parameter int N = 32
);

  logic [N-1:0] if_pc;
  logic         if_pred_taken;
  logic         id_branch;
  logic [N-1:0] id_pc;
  logic         id_pred_taken;
  logic [N-1:0] id_target;
  logic         id_hazard;
  logic [N-1:0] data1;
  logic [N-1:0] data2;
  logic         stall;
  logic         flush;
  logic         redirect_valid;
  logic [N-1:0] redirect_pc;
  logic         resolved_taken;
`ifdef BP_PERF_CNT_EN
  logic [31:0]  perf_branches;
  logic [31:0]  perf_mispredicts;

  modport master (
    output if_pc, id_branch, id_pc, id_pred_taken, id_target, id_hazard, data1, data2,
    input  if_pred_taken, stall, flush, redirect_valid, redirect_pc, resolved_taken,
    input  perf_branches, perf_mispredicts
  );

  modport slave (
    input  if_pc, id_branch, id_pc, id_pred_taken, id_target, id_hazard, data1, data2,
    output if_pred_taken, stall, flush, redirect_valid, redirect_pc, resolved_taken,
    output perf_branches, perf_mispredicts
  );
`else
  modport master (
    output if_pc, id_branch, id_pc, id_pred_taken, id_target, id_hazard, data1, data2,
    input  if_pred_taken, stall, flush, redirect_valid, redirect_pc, resolved_taken
  );

  modport slave (
    input  if_pc, id_branch, id_pc, id_pred_taken, id_target, id_hazard, data1, data2,
    output if_pred_taken, stall, flush, redirect_valid, redirect_pc, resolved_taken
  );
`endif

endinterface

// File: rtl/branch_resolve_ctrl_bht_2bit.sv
// M-entry table of 2-bit saturating counters: asynchronous read, synchronous update.
// A same-index read during an update returns the old counter (no bypass).
module bht_2bit
  import bp_pkg::*;
#(
  parameter int M     = 16,
  parameter int IDX_W = $clog2(M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] bht_q [M];
  logic [1:0] bht_d [M];

  // next value of every counter; only the addressed entry moves
  always_comb begin
    for (int i = 0; i < M; i++) begin
      if (wr_en && (wr_idx == IDX_W'(i))) begin
        bht_d[i] = sat_update(bht_q[i], wr_taken);
      end else begin
        bht_d[i] = bht_q[i];
      end
    end
  end

  // counter storage, all entries start strongly taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < M; i++) begin
        bht_q[i] <= BHT_RESET;
      end
    end else begin
      for (int i = 0; i < M; i++) begin
        bht_q[i] <= bht_d[i];
      end
    end
  end

  assign rd_ctr = bht_q[rd_idx];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolver: BEQ compare, hazard stall, mispredict flush/redirect, BHT training.
// Optional macro BP_PERF_CNT_EN adds perf_branches / perf_mispredicts counters.
module branch_resolve_ctrl
  import bp_pkg::*;
#(
  parameter int N = 32,
  parameter int M = 16
) (
  input logic                  clk,
  input logic                  rst,
  branch_resolve_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(M);

  state_e       state_q;
  state_e       state_d;
  logic         stall_s;
  logic         resolve_s;
  logic         taken_s;
  logic         mismatch_s;
  logic         mispredict_s;
  logic         flush_q;
  logic         flush_d;
  logic         redirect_valid_q;
  logic         redirect_valid_d;
  logic         resolved_taken_q;
  logic         resolved_taken_d;
  logic [N-1:0] redirect_pc_q;
  logic [N-1:0] redirect_pc_d;
  logic [1:0]   if_ctr_s;
  logic         unused_bits_s;

  assign taken_s    = (bus.data1 == bus.data2);
  assign mismatch_s = (taken_s != bus.id_pred_taken);

  // resolver FSM: decides stall, resolve and the next state
  always_comb begin
    state_d   = state_q;
    stall_s   = 1'b0;
    resolve_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.id_branch && bus.id_hazard) begin
          stall_s = 1'b1;
          state_d = WAIT_OPND;
        end else if (bus.id_branch) begin
          resolve_s = 1'b1;
          state_d   = mismatch_s ? FLUSH : IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_OPND: begin
        if (bus.id_hazard) begin
          stall_s = 1'b1;
          state_d = WAIT_OPND;
        end else begin
          resolve_s = 1'b1;
          state_d   = mismatch_s ? FLUSH : IDLE;
        end
      end
      FLUSH: begin
        // the ID instruction is being squashed, so id_branch is ignored here
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    mispredict_s = resolve_s && mismatch_s;
  end

  // next values of the registered resolution outputs
  always_comb begin
    flush_d          = mispredict_s;
    redirect_valid_d = mispredict_s;
    resolved_taken_d = resolved_taken_q;
    redirect_pc_d    = redirect_pc_q;
    if (resolve_s) begin
      resolved_taken_d = taken_s;
    end else begin
      resolved_taken_d = resolved_taken_q;
    end
    if (mispredict_s) begin
      redirect_pc_d = taken_s ? bus.id_target : (bus.id_pc + N'(PC_STEP));
    end else begin
      redirect_pc_d = redirect_pc_q;
    end
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      resolved_taken_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      resolved_taken_q <= resolved_taken_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  bht_2bit #(
    .M     (M),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (bus.if_pc[IDX_W+1:2]),
    .rd_ctr   (if_ctr_s),
    .wr_en    (resolve_s),
    .wr_idx   (bus.id_pc[IDX_W+1:2]),
    .wr_taken (taken_s)
  );

  // stall is gated by rst so a reset aborts a stall without waiting for a clock
  assign bus.stall          = stall_s & ~rst;
  assign bus.if_pred_taken  = if_ctr_s[1];
  assign bus.flush          = flush_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.resolved_taken = resolved_taken_q;

  assign unused_bits_s = ^{bus.if_pc[N-1:IDX_W+2], bus.if_pc[1:0], if_ctr_s[0]};

`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_branches_q;
  logic [31:0] perf_branches_d;
  logic [31:0] perf_mispredicts_q;
  logic [31:0] perf_mispredicts_d;

  // event counters, free-running and wrapping
  always_comb begin
    if (resolve_s) begin
      perf_branches_d = perf_branches_q + 32'd1;
    end else begin
      perf_branches_d = perf_branches_q;
    end
    if (mispredict_s) begin
      perf_mispredicts_d = perf_mispredicts_q + 32'd1;
    end else begin
      perf_mispredicts_d = perf_mispredicts_q;
    end
  end

  // counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_branches_q    <= 32'd0;
      perf_mispredicts_q <= 32'd0;
    end else begin
      perf_branches_q    <= perf_branches_d;
      perf_mispredicts_q <= perf_mispredicts_d;
    end
  end

  assign bus.perf_branches    = perf_branches_q;
  assign bus.perf_mispredicts = perf_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed steps plus randomized branches
// against a table-of-counters reference model.
module tb_branch_resolve_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  branch_resolve_ctrl_if #(.N(32)) bus ();

  branch_resolve_ctrl #(.N(32), .M(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  int bht_m [16];
  int exp_branches = 0;
  int exp_mis      = 0;
  logic last_taken = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd16);
  endfunction

  function automatic logic pred_of(input logic [31:0] pc);
    return (bht_m[idx_of(pc)] >= 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) bht_m[i] = 3;
    exp_branches = 0;
    exp_mis      = 0;
    last_taken   = 1'b0;
  endtask

  task automatic check_perf();
`ifdef BP_PERF_CNT_EN
    check("perf_branches", bus.perf_branches, exp_branches);
    check("perf_mispredicts", bus.perf_mispredicts, exp_mis);
`endif
  endtask

  // one branch in ID with haz hazard cycles; starts and ends 1 time unit after a rising edge
  task automatic do_branch(input logic [31:0] pc, input logic pred, input logic [31:0] target,
                           input logic [31:0] d1, input logic [31:0] d2, input int haz,
                           input logic [31:0] ifpc);
    logic taken;
    logic mis;
    bus.id_branch     = 1'b1;
    bus.id_pc         = pc;
    bus.id_pred_taken = pred;
    bus.id_target     = target;
    bus.data1         = d1;
    bus.data2         = d2;
    bus.if_pc         = ifpc;
    for (int i = 0; i < haz; i++) begin
      bus.id_hazard = 1'b1;
      #2;
      check("stall_hazard", bus.stall, 32'd1);
      check("if_pred_wait", bus.if_pred_taken, pred_of(ifpc));
      @(posedge clk); #1;
      check("flush_wait", bus.flush, 32'd0);
    end
    bus.id_hazard = 1'b0;
    #2;
    check("stall_resolve", bus.stall, 32'd0);
    check("if_pred_resolve", bus.if_pred_taken, pred_of(ifpc));
    @(posedge clk); #1;
    taken = (d1 == d2);
    mis   = (taken != pred);
    if (taken) bht_m[idx_of(pc)] = (bht_m[idx_of(pc)] == 3) ? 3 : bht_m[idx_of(pc)] + 1;
    else       bht_m[idx_of(pc)] = (bht_m[idx_of(pc)] == 0) ? 0 : bht_m[idx_of(pc)] - 1;
    exp_branches++;
    if (mis) exp_mis++;
    last_taken = taken;
    check("resolved_taken", bus.resolved_taken, taken);
    check("flush_pulse", bus.flush, mis);
    check("redirect_valid", bus.redirect_valid, mis);
    if (mis) check("redirect_pc", bus.redirect_pc, taken ? target : pc + 32'd4);
    check_perf();
    if (mis) begin
      // squashed instruction in ID: whatever it shows must be ignored
      bus.id_branch = 1'($urandom_range(0, 1));
      bus.id_hazard = 1'($urandom_range(0, 1));
      bus.data1     = $urandom;
      bus.data2     = $urandom;
      #2;
      check("stall_flush", bus.stall, 32'd0);
      @(posedge clk); #1;
      check("flush_end", bus.flush, 32'd0);
      check("redirect_end", bus.redirect_valid, 32'd0);
    end
    bus.id_branch = 1'b0;
    bus.id_hazard = 1'b0;
  endtask

  task automatic idle_cycle();
    bus.id_branch = 1'b0;
    bus.id_hazard = 1'b0;
    #2;
    check("stall_idle", bus.stall, 32'd0);
    @(posedge clk); #1;
    check("flush_idle", bus.flush, 32'd0);
    check("resolved_hold", bus.resolved_taken, last_taken);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] ifpc;
    logic [31:0] probe [3];

    rst = 1'b1;
    bus.if_pc = 32'h0; bus.id_branch = 1'b0; bus.id_pc = 32'h0; bus.id_pred_taken = 1'b0;
    bus.id_target = 32'h0; bus.id_hazard = 1'b0; bus.data1 = 32'h0; bus.data2 = 32'h0;
    model_reset();
    #12;
    check("rst_flush", bus.flush, 32'd0);
    check("rst_redirect_valid", bus.redirect_valid, 32'd0);
    check("rst_redirect_pc", bus.redirect_pc, 32'd0);
    check("rst_resolved", bus.resolved_taken, 32'd0);
    check("rst_stall", bus.stall, 32'd0);
    check_perf();
    probe[0] = 32'h00; probe[1] = 32'h04; probe[2] = 32'h3C;
    for (int i = 0; i < 3; i++) begin
      bus.if_pc = probe[i];
      #1;
      check("rst_if_pred", bus.if_pred_taken, 32'd1);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // correct taken prediction, then four not-taken mispredicts walking 11->10->01->00->00
    do_branch(32'h10, 1'b1, 32'h80, 32'd5, 32'd5, 0, 32'h10);
    for (int r = 0; r < 4; r++) begin
      do_branch(32'h10, 1'b1, 32'h80, 32'd5, 32'd6, 0, 32'h10);
    end
    bus.if_pc = 32'h10;
    #1;
    check("bht4_saturated_nt", bus.if_pred_taken, 32'd0);
    check("bht4_model", 32'(bht_m[4]), 32'd0);
    @(posedge clk); #1;

    // three hazard cycles, taken with predicted not-taken -> redirect to target
    do_branch(32'h20, 1'b0, 32'h80, 32'd7, 32'd7, 3, 32'h24);
    // back-to-back correctly predicted branches
    do_branch(32'h30, 1'b1, 32'h100, 32'd1, 32'd1, 0, 32'h30);
    do_branch(32'h34, 1'b1, 32'h100, 32'd2, 32'd2, 0, 32'h30);
    // PC+4 wraps at the top of the address space
    do_branch(32'hFFFF_FFFC, 1'b1, 32'h200, 32'd1, 32'd2, 0, 32'h3C);
    idle_cycle();

    // reset while waiting on operands
    bus.id_branch = 1'b1; bus.id_pc = 32'h40; bus.id_pred_taken = 1'b1; bus.id_hazard = 1'b1;
    @(posedge clk); #1;
    check("wait_stall", bus.stall, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_abort_stall", bus.stall, 32'd0);
    check("rst_abort_flush", bus.flush, 32'd0);
    check("rst_abort_resolved", bus.resolved_taken, 32'd0);
    model_reset();
    check_perf();
    for (int i = 0; i < 16; i++) begin
      bus.if_pc = 32'(i * 4);
      #0.1;
      check("rst_bht_all", bus.if_pred_taken, 32'd1);
    end
    bus.id_branch = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    #2;
    check("post_rst_idle_nostall", bus.stall, 32'd0);
    @(posedge clk); #1;
    bus.id_hazard = 1'b0;

    // randomized branches against the model
    for (int n = 0; n < 150; n++) begin
      pc   = $urandom & 32'hFFFF_FFFC;
      d1   = $urandom_range(0, 3);
      d2   = ($urandom_range(0, 1) == 1) ? d1 : 32'($urandom_range(0, 3));
      ifpc = ($urandom_range(0, 2) == 0) ? pc : ($urandom & 32'hFFFF_FFFC);
      do_branch(pc, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, d1, d2,
                ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3)), ifpc);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
